// File: rtl/sdram_ch_bridge.sv
// sdram_ch_bridge
//   Host-side front end for one byte channel of the 3-channel SDRAM
//   controller. Host requests are queued in a small FIFO. Each request is
//   replayed to the controller as a rd/wr strobe that is held until the
//   controller raises busy. Read bytes come back as in-order one-cycle
//   response pulses. Writes are posted and produce no response.
//
//   Optional feature macro: SDRAM_BRIDGE_TIMEOUT_EN
//     When it is defined, a request whose strobe is not answered by ch_busy
//     within TIMEOUT_CYC cycles is abandoned. An abandoned read returns
//     rsp_err=1 with rsp_data=8'hFF. An abandoned write is dropped silently.
//     When it is undefined, the bridge waits forever and rsp_err is always 0.
//
// Ports
//   clk, reset_n            controller clock; asynchronous active-low reset
//   req_valid/req_ready     host request handshake (ready = FIFO not full)
//   req_we/addr/wdata       1=write; 25-bit byte address; write byte
//   rsp_valid/data/err      read completion pulse, read byte, timeout flag
//   ch_addr/rd/wr/din       to controller chN_addr/rd/wr/din
//   ch_dout, ch_busy        from controller chN_dout/busy
//   fifo_level              number of occupied FIFO entries
//   idle                    FIFO empty and FSM in IDLE
module sdram_ch_bridge #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [24:0]                   req_addr,
  input  logic [7:0]                    req_wdata,
  output logic                          rsp_valid,
  output logic [7:0]                    rsp_data,
  output logic                          rsp_err,
  output logic [24:0]                   ch_addr,
  output logic                          ch_rd,
  output logic                          ch_wr,
  output logic [7:0]                    ch_din,
  input  logic [7:0]                    ch_dout,
  input  logic                          ch_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [33:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_d;
  logic          push, pop;
  logic [33:0]   head;

  logic          ch_rd_d, ch_wr_d, cur_we, cur_we_d, rsp_valid_d;
  logic [24:0]   ch_addr_d;
  logic [7:0]    ch_din_d, rsp_data_d;

  // A push is gated by the registered ready, so a full FIFO refuses a push
  // even if a pop happens in the same cycle.
  assign push = req_valid & req_ready;
  assign pop  = (state == ST_IDLE) && (level != '0);
  assign head = fifo_mem[rd_ptr];

  assign fifo_level = level;
  assign idle       = (state == ST_IDLE) && (level == '0);

  // Storage has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_we, req_addr, req_wdata};
  end

  always_comb begin
    level_d = level + LW'(push) - LW'(pop);
  end

  // Pointers wrap naturally because the depth is a power of two. Ready is
  // computed from the next level so it is exact on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      req_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level     <= level_d;
      req_ready <= (level_d != LW'(FIFO_DEPTH));
    end
  end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic          rsp_err_d;
`endif

  // Next-state logic. The strobe is registered, so it rises the cycle after
  // the pop and falls the cycle after ch_busy is first seen high. Address and
  // data are left untouched until the next pop, so they stay stable through
  // WAIT. GAP guarantees one strobe-low cycle before the next request so the
  // controller's edge detector re-arms.
  always_comb begin
    state_d     = state;
    ch_rd_d     = ch_rd;
    ch_wr_d     = ch_wr;
    ch_addr_d   = ch_addr;
    ch_din_d    = ch_din;
    cur_we_d    = cur_we;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt;
    rsp_err_d   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pop) begin
          cur_we_d  = head[33];
          ch_addr_d = head[32:8];
          ch_din_d  = head[7:0];
          ch_wr_d   = head[33];
          ch_rd_d   = ~head[33];
          state_d   = ST_ISSUE;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_ISSUE: begin
        if (ch_busy) begin
          ch_rd_d = 1'b0;
          ch_wr_d = 1'b0;
          state_d = ST_WAIT;
        end
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          ch_rd_d = 1'b0;
          ch_wr_d = 1'b0;
          state_d = ST_GAP;
          if (!cur_we) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'hFF;
            rsp_err_d   = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
`endif
      end
      ST_WAIT: begin
        if (!ch_busy) begin
          if (!cur_we) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = ch_dout;
          end
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ch_rd     <= 1'b0;
      ch_wr     <= 1'b0;
      ch_addr   <= '0;
      ch_din    <= '0;
      cur_we    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_d;
      ch_rd     <= ch_rd_d;
      ch_wr     <= ch_wr_d;
      ch_addr   <= ch_addr_d;
      ch_din    <= ch_din_d;
      cur_we    <= cur_we_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
    end
  end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_d;
      rsp_err <= rsp_err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
